// File: rtl/connection_ctrl_client.sv
// Control-plane initiator: takes activate/deactivate commands from software, issues each as a
// single request beat to the connection manager, waits for ack/full or a timeout, and returns
// one result beat per command. Saturating statistics track the outcome of every command.
module connection_ctrl_client #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        s00_axis_aclk,
   input  logic        s00_axis_aresetn,
   // Software command stream
   input  logic        s00_axis_tvalid,
   output logic        s00_axis_tready,
   input  logic [63:0] s00_axis_tdata,
   input  logic        s00_axis_tlast,
   input  logic [7:0]  s00_axis_tstrb,
   // Request to connection manager
   output logic        m02_axis_tvalid,
   input  logic        m02_axis_tready,
   output logic [63:0] m02_axis_tdata,
   output logic        m02_axis_tlast,
   output logic [7:0]  m02_axis_tstrb,
   // Response from connection manager
   input  logic        s02_axis_tvalid,
   output logic        s02_axis_tready,
   input  logic [63:0] s02_axis_tdata,
   input  logic        s02_axis_tlast,
   input  logic [7:0]  s02_axis_tstrb,
   // Result stream back to software
   output logic        m00_axis_tvalid,
   input  logic        m00_axis_tready,
   output logic [63:0] m00_axis_tdata,
   output logic        m00_axis_tlast,
   output logic [7:0]  m00_axis_tstrb,
   // Status and statistics
   output logic        busy,
   output logic [15:0] ack_count,
   output logic [15:0] nack_count,
   output logic [15:0] timeout_count,
   output logic [15:0] stale_count
);

   localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StReport} state_t;

   state_t      state;
   logic [15:0] timer;

   // Fields the block deliberately ignores
   logic unused_inputs;
   assign unused_inputs = ^{s00_axis_tdata[63:33], s00_axis_tlast, s00_axis_tstrb,
                            s02_axis_tdata[63:2], s02_axis_tlast, s02_axis_tstrb};

   // Constant framing; responses are always accepted so late replies never back up the manager
   assign m02_axis_tlast  = 1'b1;
   assign m02_axis_tstrb  = 8'hFF;
   assign m00_axis_tlast  = 1'b1;
   assign m00_axis_tstrb  = 8'hFF;
   assign s02_axis_tready = 1'b1;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Command FSM with registered handshake outputs, result data and statistics
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state           <= StIdle;
         timer           <= '0;
         s00_axis_tready <= 1'b1;
         m02_axis_tvalid <= 1'b0;
         m02_axis_tdata  <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
         busy            <= 1'b0;
         ack_count       <= '0;
         nack_count      <= '0;
         timeout_count   <= '0;
         stale_count     <= '0;
      end else begin
         // Any response outside WAIT_RESP belongs to no outstanding command
         if (s02_axis_tvalid && (state != StWaitResp)) begin
            stale_count <= sat_inc(stale_count);
         end

         unique case (state)
            StIdle: begin
               if (s00_axis_tvalid && s00_axis_tready) begin
                  // The request register doubles as the latched command
                  m02_axis_tdata  <= {31'd0, s00_axis_tdata[32:0]};
                  m02_axis_tvalid <= 1'b1;
                  s00_axis_tready <= 1'b0;
                  busy            <= 1'b1;
                  state           <= StIssue;
               end
            end
            StIssue: begin
               if (m02_axis_tready) begin
                  m02_axis_tvalid <= 1'b0;
                  timer           <= '0;
                  state           <= StWaitResp;
               end
            end
            StWaitResp: begin
               timer <= timer + 16'd1;
               // A response on the expiry cycle takes priority over the timeout
               if (s02_axis_tvalid) begin
                  m00_axis_tdata  <= {28'd0, 1'b0, s02_axis_tdata[1], s02_axis_tdata[0],
                                      m02_axis_tdata[32:0]};
                  m00_axis_tvalid <= 1'b1;
                  state           <= StReport;
               end else if (timer == TimerLast) begin
                  m00_axis_tdata  <= {28'd0, 3'b100, m02_axis_tdata[32:0]};
                  m00_axis_tvalid <= 1'b1;
                  state           <= StReport;
               end
            end
            StReport: begin
               if (m00_axis_tready) begin
                  if (m00_axis_tdata[35]) begin
                     timeout_count <= sat_inc(timeout_count);
                  end else if (m00_axis_tdata[33]) begin
                     ack_count <= sat_inc(ack_count);
                  end else begin
                     nack_count <= sat_inc(nack_count);
                  end
                  m00_axis_tvalid <= 1'b0;
                  s00_axis_tready <= 1'b1;
                  busy            <= 1'b0;
                  state           <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
